decode_stage_hz: RTL and testbench

- Parametrised successor to the single-issue decode stage: decode, register read and ID/EX pipeline register.
- Adds write-through register-file bypass, load-use hazard detection with a stall output, EX flush / bubble insertion, and a per-slot valid bit.
- Sits between the IF/ID register and the execute stage. Reuses the existing Ctrl_Unit and Sign_Extend modules unchanged.

---
 rtl/decode_pkg.sv | 28 ++
 rtl/decode_stage_hz_if.sv | 48 ++++
 rtl/Ctrl_Unit.sv | 54 +++++
 rtl/Sign_Extend.sv | 20 ++
 rtl/load_use_detect.sv | 23 ++
 rtl/decode_stage_hz.sv | 166 ++++++++++++++++
 tb/tb_decode_stage_hz.sv | 224 ++++++++++++++++++++++
 7 files changed

// File: rtl/decode_pkg.sv
// Shared decode types and constants: opcodes, ALU encodings, control word and its bubble value.
// Imported by the control decoder, the hazard detector and the decode stage top.
package decode_pkg;

   localparam logic [6:0] OP_R   = 7'b0110011;
   localparam logic [6:0] OP_I   = 7'b0010011;
   localparam logic [6:0] OP_LW  = 7'b0000011;
   localparam logic [6:0] OP_SW  = 7'b0100011;
   localparam logic [6:0] OP_BEQ = 7'b1100011;

   localparam logic [2:0] ALU_ADD = 3'b000;
   localparam logic [2:0] ALU_SUB = 3'b001;
   localparam logic [2:0] ALU_AND = 3'b010;
   localparam logic [2:0] ALU_OR  = 3'b011;
   localparam logic [2:0] ALU_SLT = 3'b101;

   typedef struct packed {
      logic       reg_wrt;
      logic       result_src;
      logic       mem_wrt;
      logic       branch;
      logic       alu_src;
      logic [2:0] alu_control;
   } ctrl_t;

   localparam ctrl_t CTRL_BUBBLE = '0;

endpackage

// File: rtl/decode_stage_hz_if.sv
// Decode-stage bus: IF/ID inputs, writeback port, EX-register outputs and perf counters.
// master = upstream/downstream pipeline side, slave = the decode stage.
interface decode_stage_hz_if #(
   parameter int XLEN   = 32,
   parameter int REG_AW = 5
);
   logic [31:0]       InstrDe;
   logic [XLEN-1:0]   PCDe;
   logic [XLEN-1:0]   PCplus4De;
   logic              ValidDe;
   logic              FlushE;
   logic              RegWrtW;
   logic [REG_AW-1:0] RDW;
   logic [XLEN-1:0]   ResultW;

   logic              StallD;
   logic              ValidEx;
   logic              RegWrtEx;
   logic              ALUSrcEx;
   logic              MemWrtEx;
   logic              ResultSrcEx;
   logic              BranchEx;
   logic [2:0]        ALUControlEx;
   logic [XLEN-1:0]   RD1Ex;
   logic [XLEN-1:0]   RD2Ex;
   logic [XLEN-1:0]   Imm_ExtEx;
   logic [REG_AW-1:0] RS1Ex;
   logic [REG_AW-1:0] RS2Ex;
   logic [REG_AW-1:0] RDEx;
   logic [XLEN-1:0]   PCEx;
   logic [XLEN-1:0]   PCplus4Ex;
   logic [31:0]       StallCnt;
   logic [31:0]       FlushCnt;

   modport master (
      output InstrDe, PCDe, PCplus4De, ValidDe, FlushE, RegWrtW, RDW, ResultW,
      input  StallD, ValidEx, RegWrtEx, ALUSrcEx, MemWrtEx, ResultSrcEx, BranchEx,
      input  ALUControlEx, RD1Ex, RD2Ex, Imm_ExtEx, RS1Ex, RS2Ex, RDEx, PCEx, PCplus4Ex,
      input  StallCnt, FlushCnt
   );

   modport slave (
      input  InstrDe, PCDe, PCplus4De, ValidDe, FlushE, RegWrtW, RDW, ResultW,
      output StallD, ValidEx, RegWrtEx, ALUSrcEx, MemWrtEx, ResultSrcEx, BranchEx,
      output ALUControlEx, RD1Ex, RD2Ex, Imm_ExtEx, RS1Ex, RS2Ex, RDEx, PCEx, PCplus4Ex,
      output StallCnt, FlushCnt
   );
endinterface

// File: rtl/Ctrl_Unit.sv
// Main + ALU control decoder for the RV32 subset (R, I-ALU, lw, sw, beq); purely combinational.
// Unknown opcodes decode to an all-zero control word.
module Ctrl_Unit
   import decode_pkg::*;
(
   input  logic [6:0] op,
   input  logic [2:0] funct3,
   input  logic [6:0] funct7,
   output logic       RegWrite,
   output logic       ResultSrc,
   output logic       MemWrite,
   output logic       Branch,
   output logic       ALUSrc,
   output logic [1:0] ImmSrc,
   output logic [2:0] ALUControl
);
   logic [1:0] alu_op;
   logic       unused_f7;

   assign unused_f7 = ^{funct7[6], funct7[4:0]};

   always_comb begin
      RegWrite  = 1'b0;
      ResultSrc = 1'b0;
      MemWrite  = 1'b0;
      Branch    = 1'b0;
      ALUSrc    = 1'b0;
      ImmSrc    = 2'b00;
      alu_op    = 2'b00;
      case (op)
         OP_LW:  begin RegWrite = 1'b1; ALUSrc = 1'b1; ResultSrc = 1'b1; end
         OP_SW:  begin MemWrite = 1'b1; ALUSrc = 1'b1; ImmSrc = 2'b01; end
         OP_R:   begin RegWrite = 1'b1; alu_op = 2'b10; end
         OP_BEQ: begin Branch = 1'b1; ImmSrc = 2'b10; alu_op = 2'b01; end
         OP_I:   begin RegWrite = 1'b1; ALUSrc = 1'b1; alu_op = 2'b10; end
         default: ;
      endcase
   end

   always_comb begin
      ALUControl = ALU_ADD;
      if (alu_op == 2'b01) begin
         ALUControl = ALU_SUB;
      end else if (alu_op == 2'b10) begin
         case (funct3)
            3'b000:  ALUControl = (op[5] && funct7[5]) ? ALU_SUB : ALU_ADD;
            3'b010:  ALUControl = ALU_SLT;
            3'b110:  ALUControl = ALU_OR;
            3'b111:  ALUControl = ALU_AND;
            default: ALUControl = ALU_ADD;
         endcase
      end
   end
endmodule

// File: rtl/Sign_Extend.sv
// Immediate generator: I (00), S (01) and B (10) formats sign-extended to 32 bits; 11 yields 0.
// Purely combinational.
module Sign_Extend (
   input  logic [31:0] Instr,
   input  logic [1:0]  ImmSrc,
   output logic [31:0] ImmExt
);
   logic unused_op;

   assign unused_op = ^Instr[6:0];

   always_comb begin
      case (ImmSrc)
         2'b00:   ImmExt = {{20{Instr[31]}}, Instr[31:20]};
         2'b01:   ImmExt = {{20{Instr[31]}}, Instr[31:25], Instr[11:7]};
         2'b10:   ImmExt = {{20{Instr[31]}}, Instr[7], Instr[30:25], Instr[11:8], 1'b0};
         default: ImmExt = '0;
      endcase
   end
endmodule

// File: rtl/load_use_detect.sv
// Load-use hazard check between the instruction in ID and a load sitting in EX; combinational.
// rs2 only counts for formats that actually read it (R, S, B).
module load_use_detect
   import decode_pkg::*;
#(
   parameter int REG_AW = 5
) (
   input  logic [6:0]        opcode,
   input  logic [REG_AW-1:0] rs1,
   input  logic [REG_AW-1:0] rs2,
   input  logic              valid_de,
   input  logic              valid_ex,
   input  logic              result_src_ex,
   input  logic              reg_wrt_ex,
   input  logic [REG_AW-1:0] rd_ex,
   output logic              uses_rs2,
   output logic              load_use
);
   assign uses_rs2 = (opcode == OP_R) || (opcode == OP_SW) || (opcode == OP_BEQ);

   assign load_use = valid_de && valid_ex && result_src_ex && reg_wrt_ex && (rd_ex != '0)
                     && ((rd_ex == rs1) || (uses_rs2 && (rd_ex == rs2)));
endmodule

// File: rtl/decode_stage_hz.sv
// Decode + regfile (write-through) + ID/EX register with load-use stall and EX flush; 1-cycle ID->EX.
// StallD holds IF/ID for one cycle per load-use pair; DECODE_PERF_CNT_EN builds stall/flush counters.
module decode_stage_hz
   import decode_pkg::*;
#(
   parameter int              XLEN   = 32,
   parameter int              REG_AW = 5,
   parameter logic [XLEN-1:0] RST_PC = '0
) (
   input logic              clk,
   input logic              rst,
   decode_stage_hz_if.slave bus
);
   typedef struct packed {
      logic              valid;
      ctrl_t             ctrl;
      logic [XLEN-1:0]   rd1;
      logic [XLEN-1:0]   rd2;
      logic [XLEN-1:0]   imm;
      logic [REG_AW-1:0] rs1;
      logic [REG_AW-1:0] rs2;
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   pc;
      logic [XLEN-1:0]   pc4;
   } ex_t;

   localparam ex_t EX_BUBBLE = '{valid: 1'b0, ctrl: CTRL_BUBBLE, rd1: '0, rd2: '0, imm: '0,
                                 rs1: '0, rs2: '0, rd: '0, pc: RST_PC, pc4: RST_PC};

   ex_t               ex_q, ex_d;
   logic [XLEN-1:0]   rf_q [2**REG_AW];
   logic [XLEN-1:0]   rf_d [2**REG_AW];
   logic [REG_AW-1:0] rs1_de, rs2_de, rd_de;
   logic [XLEN-1:0]   rd1_de, rd2_de, imm_de;
   logic [31:0]       imm32_de;
   logic [1:0]        imm_src_de;
   logic              reg_wrt_de, result_src_de, mem_wrt_de, branch_de, alu_src_de;
   logic [2:0]        alu_control_de;
   logic              wb_en, load_use, stall_d, uses_rs2_unused;

   assign rs1_de = REG_AW'(bus.InstrDe[19:15]);
   assign rs2_de = REG_AW'(bus.InstrDe[24:20]);
   assign rd_de  = REG_AW'(bus.InstrDe[11:7]);

   Ctrl_Unit u_ctrl (
      .op        (bus.InstrDe[6:0]),
      .funct3    (bus.InstrDe[14:12]),
      .funct7    (bus.InstrDe[31:25]),
      .RegWrite  (reg_wrt_de),
      .ResultSrc (result_src_de),
      .MemWrite  (mem_wrt_de),
      .Branch    (branch_de),
      .ALUSrc    (alu_src_de),
      .ImmSrc    (imm_src_de),
      .ALUControl(alu_control_de)
   );

   Sign_Extend u_sext (
      .Instr (bus.InstrDe),
      .ImmSrc(imm_src_de),
      .ImmExt(imm32_de)
   );

   assign imm_de = XLEN'($signed(imm32_de));

   // Writeback in the same cycle as the read is forwarded so ID never sees stale data.
   assign wb_en  = bus.RegWrtW && (bus.RDW != '0);
   assign rd1_de = (rs1_de == '0) ? '0 : (wb_en && (bus.RDW == rs1_de)) ? bus.ResultW : rf_q[rs1_de];
   assign rd2_de = (rs2_de == '0) ? '0 : (wb_en && (bus.RDW == rs2_de)) ? bus.ResultW : rf_q[rs2_de];

   always_comb begin
      rf_d = rf_q;
      if (wb_en) begin
         rf_d[bus.RDW] = bus.ResultW;
      end
   end

   load_use_detect #(.REG_AW(REG_AW)) u_lud (
      .opcode       (bus.InstrDe[6:0]),
      .rs1          (rs1_de),
      .rs2          (rs2_de),
      .valid_de     (bus.ValidDe),
      .valid_ex     (ex_q.valid),
      .result_src_ex(ex_q.ctrl.result_src),
      .reg_wrt_ex   (ex_q.ctrl.reg_wrt),
      .rd_ex        (ex_q.rd),
      .uses_rs2     (uses_rs2_unused),
      .load_use     (load_use)
   );

   // A taken branch kills the younger instruction anyway, so it overrides the stall.
   assign stall_d = load_use && !bus.FlushE && rst;

   always_comb begin
      ex_d = EX_BUBBLE;
      if (!bus.FlushE && !stall_d && bus.ValidDe) begin
         ex_d.valid                = 1'b1;
         ex_d.ctrl.reg_wrt         = reg_wrt_de;
         ex_d.ctrl.result_src      = result_src_de;
         ex_d.ctrl.mem_wrt         = mem_wrt_de;
         ex_d.ctrl.branch          = branch_de;
         ex_d.ctrl.alu_src         = alu_src_de;
         ex_d.ctrl.alu_control     = alu_control_de;
         ex_d.rd1                  = rd1_de;
         ex_d.rd2                  = rd2_de;
         ex_d.imm                  = imm_de;
         ex_d.rs1                  = rs1_de;
         ex_d.rs2                  = rs2_de;
         ex_d.rd                   = rd_de;
         ex_d.pc                   = bus.PCDe;
         ex_d.pc4                  = bus.PCplus4De;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ex_q <= EX_BUBBLE;
         rf_q <= '{default: '0};
      end else begin
         ex_q <= ex_d;
         rf_q <= rf_d;
      end
   end

`ifdef DECODE_PERF_CNT_EN
   logic [31:0] stall_cnt_q, stall_cnt_d, flush_cnt_q, flush_cnt_d;

   always_comb begin
      stall_cnt_d = stall_cnt_q + 32'(stall_d);
      flush_cnt_d = flush_cnt_q + 32'(bus.FlushE);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign bus.StallCnt = stall_cnt_q;
   assign bus.FlushCnt = flush_cnt_q;
`else
   assign bus.StallCnt = '0;
   assign bus.FlushCnt = '0;
`endif

   assign bus.StallD       = stall_d;
   assign bus.ValidEx      = ex_q.valid;
   assign bus.RegWrtEx     = ex_q.ctrl.reg_wrt;
   assign bus.ALUSrcEx     = ex_q.ctrl.alu_src;
   assign bus.MemWrtEx     = ex_q.ctrl.mem_wrt;
   assign bus.ResultSrcEx  = ex_q.ctrl.result_src;
   assign bus.BranchEx     = ex_q.ctrl.branch;
   assign bus.ALUControlEx = ex_q.ctrl.alu_control;
   assign bus.RD1Ex        = ex_q.rd1;
   assign bus.RD2Ex        = ex_q.rd2;
   assign bus.Imm_ExtEx    = ex_q.imm;
   assign bus.RS1Ex        = ex_q.rs1;
   assign bus.RS2Ex        = ex_q.rs2;
   assign bus.RDEx         = ex_q.rd;
   assign bus.PCEx         = ex_q.pc;
   assign bus.PCplus4Ex    = ex_q.pc4;
endmodule

// File: tb/tb_decode_stage_hz.sv
// Directed bench for decode_stage_hz: expected EX slots queued at issue, popped after the edge.
// Counter checks follow DECODE_PERF_CNT_EN.
module tb_decode_stage_hz;
   localparam logic [31:0] RST_PC = 32'h0000_0080;

   localparam logic [31:0] I_ADD   = 32'h002081B3; // add  x3,x1,x2
   localparam logic [31:0] I_WT5   = 32'h00028513; // addi x10,x5,0
   localparam logic [31:0] I_WT0   = 32'h00000593; // addi x11,x0,0
   localparam logic [31:0] I_SUB   = 32'h401284B3; // sub  x9,x5,x1
   localparam logic [31:0] I_LW    = 32'h0000A303; // lw   x6,0(x1)
   localparam logic [31:0] I_ADDLU = 32'h002303B3; // add  x7,x6,x2
   localparam logic [31:0] I_ADDI  = 32'h00608413; // addi x8,x1,6
   localparam logic [31:0] I_BEQ   = 32'h00208463; // beq  x1,x2,8
   localparam logic [31:0] I_SW    = 32'h0020A223; // sw   x2,4(x1)

   // {RegWrt, ALUSrc, MemWrt, ResultSrc, Branch, ALUControl}
   localparam logic [7:0] C_R_ADD = 8'b1000_0000;
   localparam logic [7:0] C_R_SUB = 8'b1000_0001;
   localparam logic [7:0] C_I_ADD = 8'b1100_0000;
   localparam logic [7:0] C_LW    = 8'b1101_0000;
   localparam logic [7:0] C_SW    = 8'b0110_0000;
   localparam logic [7:0] C_BEQ   = 8'b0000_1001;

   typedef struct packed {
      logic        valid;
      logic [7:0]  ctl;
      logic [31:0] rd1;
      logic [31:0] rd2;
      logic [31:0] imm;
      logic [4:0]  rs1;
      logic [4:0]  rs2;
      logic [4:0]  rd;
      logic [31:0] pc;
      logic [31:0] pc4;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b0;
   exp_t        sb_q[$];
   exp_t        mask_q[$];
   logic [31:0] rf_m [32];
   logic [31:0] pc_ctr = 32'h0000_1000;
   int          errors = 0;
   int          checks = 0;
   int          n_stall = 0;
   int          n_flush = 0;

   always #5 clk = ~clk;

   decode_stage_hz_if #(.XLEN(32), .REG_AW(5)) bus ();

   decode_stage_hz #(.XLEN(32), .REG_AW(5), .RST_PC(RST_PC)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   task automatic chk(input string tag, input logic [199:0] obs, input logic [199:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic exp_t observed();
      exp_t o;
      o.valid = bus.ValidEx;
      o.ctl   = {bus.RegWrtEx, bus.ALUSrcEx, bus.MemWrtEx, bus.ResultSrcEx, bus.BranchEx, bus.ALUControlEx};
      o.rd1   = bus.RD1Ex;
      o.rd2   = bus.RD2Ex;
      o.imm   = bus.Imm_ExtEx;
      o.rs1   = bus.RS1Ex;
      o.rs2   = bus.RS2Ex;
      o.rd    = bus.RDEx;
      o.pc    = bus.PCEx;
      o.pc4   = bus.PCplus4Ex;
      return o;
   endfunction

   function automatic exp_t bubble();
      exp_t b;
      b     = '0;
      b.pc  = RST_PC;
      b.pc4 = RST_PC;
      return b;
   endfunction

   function automatic logic [31:0] rd_m(input logic [4:0] a);
      if (a == 5'd0) return 32'h0;
      if (bus.RegWrtW && (bus.RDW == a)) return bus.ResultW;
      return rf_m[a];
   endfunction

   task automatic wb(input logic [4:0] a, input logic [31:0] d);
      bus.RegWrtW = 1'b1;
      bus.RDW     = a;
      bus.ResultW = d;
   endtask

   // Drive one ID slot, check StallD before the edge, then compare the EX slot after it.
   task automatic issue(input string tag, input logic [31:0] instr, input logic vld, input logic [7:0] ctl,
                        input logic [31:0] imm, input logic imm_care, input logic flush, input logic exp_stall);
      exp_t e, m, got;
      bus.InstrDe   = instr;
      bus.ValidDe   = vld;
      bus.FlushE    = flush;
      bus.PCDe      = pc_ctr;
      bus.PCplus4De = pc_ctr + 32'd4;
      #1;
      chk({tag, "_stall"}, 200'(bus.StallD), 200'(exp_stall));
      m = '1;
      if (flush || exp_stall || !vld) begin
         e = bubble();
      end else begin
         e.valid = 1'b1;
         e.ctl   = ctl;
         e.rd1   = rd_m(instr[19:15]);
         e.rd2   = rd_m(instr[24:20]);
         e.imm   = imm;
         e.rs1   = instr[19:15];
         e.rs2   = instr[24:20];
         e.rd    = instr[11:7];
         e.pc    = pc_ctr;
         e.pc4   = pc_ctr + 32'd4;
         if (!imm_care) m.imm = '0;
      end
      sb_q.push_back(e);
      mask_q.push_back(m);
      if (exp_stall) n_stall++;
      if (flush) n_flush++;
      @(posedge clk);
      if (bus.RegWrtW && (bus.RDW != 5'd0)) rf_m[bus.RDW] = bus.ResultW;
      #1;
      bus.RegWrtW = 1'b0;
      bus.FlushE  = 1'b0;
      got = observed();
      e   = sb_q.pop_front();
      m   = mask_q.pop_front();
      chk(tag, 200'(got & m), 200'(e & m));
      if (!exp_stall) pc_ctr += 32'd4;
   endtask

   task automatic load_use_pair(input string tag);
      issue({tag, "_lw"}, I_LW, 1'b1, C_LW, 32'd0, 1'b1, 1'b0, 1'b0);
      issue({tag, "_bubble"}, I_ADDLU, 1'b1, C_R_ADD, 32'd0, 1'b0, 1'b0, 1'b1);
      issue({tag, "_add"}, I_ADDLU, 1'b1, C_R_ADD, 32'd0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      for (int i = 0; i < 32; i++) rf_m[i] = 32'h0;
      bus.InstrDe   = I_ADD;
      bus.ValidDe   = 1'b1;
      bus.FlushE    = 1'b0;
      bus.PCDe      = 32'h0000_0400;
      bus.PCplus4De = 32'h0000_0404;
      bus.RegWrtW   = 1'b0;
      bus.RDW       = 5'd0;
      bus.ResultW   = 32'h0;

      repeat (2) @(posedge clk);
      #1;
      chk("reset_ex", 200'(observed()), 200'(bubble()));
      chk("reset_stall", 200'(bus.StallD), 200'(1'b0));
      chk("reset_cnt", 200'({bus.StallCnt, bus.FlushCnt}), 200'(64'h0));
      rst = 1'b1;

      wb(5'd1, 32'h0000_0011);
      issue("wb_x1", 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      wb(5'd2, 32'h0000_0022);
      issue("wb_x2", 32'h0, 1'b0, 8'h0, 32'h0, 1'b0, 1'b0, 1'b0);
      issue("add", I_ADD, 1'b1, C_R_ADD, 32'h0, 1'b0, 1'b0, 1'b0);

      wb(5'd5, 32'hDEAD_BEEF);
      issue("wt_x5", I_WT5, 1'b1, C_I_ADD, 32'h0, 1'b1, 1'b0, 1'b0);
      wb(5'd0, 32'h0000_1234);
      issue("wt_x0", I_WT0, 1'b1, C_I_ADD, 32'h0, 1'b1, 1'b0, 1'b0);
      issue("sub", I_SUB, 1'b1, C_R_SUB, 32'h0, 1'b0, 1'b0, 1'b0);

      wb(5'd6, 32'h0000_0066);
      load_use_pair("lu1");

      issue("lw_i", I_LW, 1'b1, C_LW, 32'd0, 1'b1, 1'b0, 1'b0);
      issue("addi_nostall", I_ADDI, 1'b1, C_I_ADD, 32'd6, 1'b1, 1'b0, 1'b0);

      load_use_pair("lu2");
      load_use_pair("lu3");

      issue("lw_f", I_LW, 1'b1, C_LW, 32'd0, 1'b1, 1'b0, 1'b0);
      issue("flush_lu", I_ADDLU, 1'b1, C_R_ADD, 32'd0, 1'b0, 1'b1, 1'b0);
      issue("flush_add", I_ADD, 1'b1, C_R_ADD, 32'd0, 1'b0, 1'b1, 1'b0);

      issue("beq", I_BEQ, 1'b1, C_BEQ, 32'd8, 1'b1, 1'b0, 1'b0);
      issue("sw", I_SW, 1'b1, C_SW, 32'd4, 1'b1, 1'b0, 1'b0);

`ifdef DECODE_PERF_CNT_EN
      chk("stall_cnt", 200'(bus.StallCnt), 200'(n_stall));
      chk("flush_cnt", 200'(bus.FlushCnt), 200'(n_flush));
      force dut.stall_cnt_q = 32'hFFFF_FFFF;
      #1;
      release dut.stall_cnt_q;
      load_use_pair("wrap");
      chk("stall_cnt_wrap", 200'(bus.StallCnt), 200'(32'h0));
`else
      chk("stall_cnt_off", 200'(bus.StallCnt), 200'(32'h0));
      chk("flush_cnt_off", 200'(bus.FlushCnt), 200'(32'h0));
`endif

      issue("lw_rst", I_LW, 1'b1, C_LW, 32'd0, 1'b1, 1'b0, 1'b0);
      bus.InstrDe = I_ADDLU;
      bus.ValidDe = 1'b1;
      #1;
      chk("pre_rst_stall", 200'(bus.StallD), 200'(1'b1));
      rst = 1'b0;
      #1;
      chk("mid_rst_stall", 200'(bus.StallD), 200'(1'b0));
      chk("mid_rst_ex", 200'(observed()), 200'(bubble()));
      chk("mid_rst_cnt", 200'({bus.StallCnt, bus.FlushCnt}), 200'(64'h0));
      chk("sb_empty", 200'(sb_q.size()), 200'(0));

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
